imem_loader: RTL and testbench

- Boot-time writer for the core's instruction memory, which the fetch path (program counter into instruction memory) only reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive word addresses through a single-cycle write strobe, then verifies a trailing checksum.
- Holds the core in reset until the load completes cleanly.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a byte stream (header word count N, N little-endian words, checksum),
// writes each word to consecutive word addresses with a one-cycle strobe,
// then compares the trailing checksum. The core is released from reset only
// after a clean load.
//
// Handshake: a byte transfers on a rising edge where i_in_valid && o_in_ready.
// o_in_ready is registered and depends only on state, so the source may hold
// i_in_valid high at any time. i_in_data is looked at only on a transfer.
`timescale 1ns/1ps
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_core_rst_n,
    output logic                  o_done,
    output logic                  o_error,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    state_t                  state_q,      state_d;
    logic [1:0]              byte_idx_q,   byte_idx_d;
    logic [23:0]             shift_q,      shift_d;
    logic [31:0]             n_q,          n_d;
    logic [31:0]             count_q,      count_d;
    logic [31:0]             sum_q,        sum_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,    wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q,    wr_data_d;
    logic                    we_q,         we_d;
    logic                    in_ready_q,   in_ready_d;
    logic                    done_q,       done_d;
    logic                    error_q,      error_d;
    logic                    core_rst_n_q, core_rst_n_d;

    logic        xfer;
    logic        word_done;
    logic [31:0] word;

    // Next-state, byte assembly and datapath; outputs derive from the next state
    // so every output is a flop and stays aligned with state_q.
    always_comb begin
        xfer      = i_in_valid && in_ready_q;
        word      = {i_in_data, shift_q};
        word_done = xfer && (byte_idx_q == 2'd3);

        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        n_d        = n_q;
        count_d    = count_q;
        sum_d      = sum_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // Bytes arrive LSB first: shifting right leaves {b2,b1,b0} after three.
        if (xfer) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {i_in_data, shift_q[23:8]};
        end

        case (state_q)
            ST_HDR: begin
                if (word_done) begin
                    if (word == 32'd0 || word > MAX_WORDS_W) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = word;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    wr_data_d = word;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                sum_d   = sum_q + wr_data_q;
                count_d = count_q + 32'd1;
                // The address stays on the last word so N == 2**ADDR_WIDTH never wraps.
                if (count_q + 32'd1 == n_q) begin
                    state_d = ST_CSUM;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (word_done) begin
                    state_d = (word == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        we_d         = (state_d == ST_WRITE);
        in_ready_d   = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
        core_rst_n_d = (state_d == ST_DONE);
    end

    // State and output registers; reset discards any partial load at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HDR;
            byte_idx_q   <= 2'd0;
            shift_q      <= 24'd0;
            n_q          <= 32'd0;
            count_q      <= 32'd0;
            sum_q        <= 32'd0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            we_q         <= 1'b0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            n_q          <= n_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            we_q         <= we_d;
            in_ready_q   <= in_ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign o_in_ready   = in_ready_q;
    assign o_we         = we_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_core_rst_n = core_rst_n_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: streams built from directed tables or $urandom,
// a reference model that parses each stream into its expected writes and
// outcome, and a monitor that pops expected writes whenever o_we is seen.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_WORDS  = 1024;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [7:0]            in_data = 8'd0;
    logic                  in_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  core_rst_n;
    logic                  done;
    logic                  error;
    logic [2:0]            dbg_state;

    always #5 clk = ~clk;

    imem_loader #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_we        (we),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_core_rst_n(core_rst_n),
        .o_done      (done),
        .o_error     (error),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int   total = 0;
    int   bad   = 0;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_q[$];
    logic [7:0] stream_q[$];
    bit   exp_done;
    bit   exp_err;
    int   consumed;

    logic [7:0] t1 [16] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00,
                            8'hA6, 8'h00, 8'h60, 8'h00};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] le32(input int i);
        return {stream_q[i+3], stream_q[i+2], stream_q[i+1], stream_q[i]};
    endfunction

    // Parse the stream: header, words at addresses 0..N-1, checksum verdict.
    task automatic model();
        logic [31:0] n;
        logic [31:0] sum;
        logic [31:0] w;
        n        = le32(0);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n == 32'd0 || n > 32'(MAX_WORDS)) begin
            exp_err  = 1'b1;
            consumed = 4;
        end else begin
            sum = 32'd0;
            for (int k = 0; k < int'(n); k++) begin
                w = le32(4 + 4 * k);
                exp_q.push_back({ADDR_WIDTH'(k), w});
                sum = sum + w;
            end
            consumed = 8 + 4 * int'(n);
            if (le32(consumed - 4) == sum) exp_done = 1'b1;
            else                           exp_err  = 1'b1;
        end
    endtask

    // ---------------- stream builders ----------------
    task automatic push_word(input logic [31:0] w);
        stream_q.push_back(w[7:0]);
        stream_q.push_back(w[15:8]);
        stream_q.push_back(w[23:16]);
        stream_q.push_back(w[31:24]);
    endtask

    task automatic build_t1(input bit bad_csum);
        stream_q.delete();
        for (int i = 0; i < 16; i++) stream_q.push_back(t1[i]);
        if (bad_csum) stream_q[15] = 8'h01;
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [31:0] sum;
        logic [31:0] w;
        stream_q.delete();
        push_word(32'(n));
        sum = 32'd0;
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            push_word(w);
            sum = sum + w;
        end
        if (corrupt) sum = sum ^ (32'd1 << $urandom_range(0, 31));
        push_word(sum);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 right after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        waited = 0;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 40) begin
                total++;
                bad++;
                $display("FAIL ready_timeout actual=ready_low_for_%0d_cycles required=ready_high", waited);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_we"},         64'(we),         64'd0);
        check({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
        check({tag, "_wr_data"},    64'(wr_data),    64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_error"},      64'(error),      64'd0);
        check({tag, "_state"},      64'(dbg_state),  64'd0);
    endtask

    // Asynchronous assert, outputs checked at once and while held, then release.
    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_values("rst_async");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst_held");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // Feed the bytes the model says will be consumed, then check the outcome
    // on the cycle right after the deciding byte.
    task automatic run_load(input string tag, input bit gaps);
        model();
        for (int i = 0; i < consumed; i++) send_byte(stream_q[i], gaps);
        @(negedge clk);
        check({tag, "_done"},       64'(done),       64'(exp_done));
        check({tag, "_error"},      64'(error),      64'(exp_err));
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
        check({tag, "_ready_off"},  64'(in_ready),   64'd0);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_sticky"},  64'(done),  64'(exp_done));
        check({tag, "_error_sticky"}, 64'(error), 64'(exp_err));
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [ADDR_WIDTH+DATA_WIDTH-1:0] e;
        if (rst && we) begin
            check("ready_during_write", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
                check("wr_data", 64'(wr_data), 64'(e[DATA_WIDTH-1:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        do_reset();

        // 1. normal load, no gaps
        build_t1(1'b0);
        run_load("t1_normal", 1'b0);

        // 2. zero length
        do_reset();
        stream_q.delete();
        push_word(32'd0);
        run_load("t2_zero", 1'b0);

        // 3. oversize header 1025
        do_reset();
        stream_q.delete();
        push_word(32'd1025);
        run_load("t3_oversize", 1'b0);

        // 4. bad checksum
        do_reset();
        build_t1(1'b1);
        run_load("t4_badcsum", 1'b0);

        // 5. backpressure and random gaps
        do_reset();
        build_t1(1'b0);
        run_load("t5_gaps", 1'b1);

        // 6. reset after 6 bytes, then full replay
        do_reset();
        build_t1(1'b0);
        for (int i = 0; i < 6; i++) send_byte(stream_q[i], 1'b0);
        #2;
        do_reset();
        run_load("t6_replay", 1'b0);

        // maximum length: last write lands on the all-ones address
        do_reset();
        build_random(MAX_WORDS, 1'b0);
        run_load("max_len", 1'b0);

        // randomized short loads, some corrupted, some with gaps
        for (int r = 0; r < 12; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            build_random(n, ($urandom_range(0, 3) == 0));
            run_load("rand_load", 1'($urandom_range(0, 1)));
        end

        // randomized oversize headers
        for (int r = 0; r < 3; r++) begin
            do_reset();
            stream_q.delete();
            push_word(32'(MAX_WORDS + 1) + 32'($urandom_range(0, 100000)));
            run_load("rand_oversize", 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
